// File: rtl/dm_bus_if.sv
// Request/response and device-window bus of the MEM-stage data-memory unit.
// The slave modport is the unit; the master modport is the pipeline plus the devices.
interface dm_bus_if #(
  parameter int DEV_COUNT = 2
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [1:0]              req_width;
  logic                    req_sext;
  logic [31:0]             req_addr;
  logic [31:0]             req_wdata;
  logic                    resp_valid;
  logic [31:0]             resp_rdata;
  logic [1:0]              resp_exc;
  logic                    dev_cyc;
  logic [DEV_COUNT-1:0]    dev_sel;
  logic                    dev_we;
  logic [31:0]             dev_addr;
  logic [31:0]             dev_wdata;
  logic [DEV_COUNT*32-1:0] dev_rdata;
  logic [DEV_COUNT-1:0]    dev_ack;
  logic [DEV_COUNT-1:0]    dev_err;

  modport slave (
    input  req_valid, req_we, req_width, req_sext, req_addr, req_wdata,
    input  dev_rdata, dev_ack, dev_err,
    output req_ready, resp_valid, resp_rdata, resp_exc,
    output dev_cyc, dev_sel, dev_we, dev_addr, dev_wdata
  );

  modport master (
    output req_valid, req_we, req_width, req_sext, req_addr, req_wdata,
    output dev_rdata, dev_ack, dev_err,
    input  req_ready, resp_valid, resp_rdata, resp_exc,
    input  dev_cyc, dev_sel, dev_we, dev_addr, dev_wdata
  );
endinterface

// File: rtl/dm_bus_unit.sv
// MEM-stage data-memory unit: internal byte-lane RAM, word-only device windows
// with an ack/timeout handshake, and address-error detection. One request at a time.
module dm_bus_unit #(
  parameter int          RAM_WORDS   = 3072,
  parameter int          DEV_COUNT   = 2,
  parameter logic [31:0] DEV_BASE    = 32'h7F00,
  parameter int          DEV_SPAN    = 16,
  parameter int          DEV_TIMEOUT = 15
) (
  input  logic     clk,
  input  logic     reset,
  dm_bus_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DEV, RESP} state_e;

  localparam int          RAM_AW    = $clog2(RAM_WORDS);
  localparam int          IDX_W     = (DEV_COUNT > 1) ? $clog2(DEV_COUNT) : 1;
  localparam int          SPAN_SH   = $clog2(DEV_SPAN);
  localparam int          CNT_W     = $clog2(DEV_TIMEOUT + 1);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam logic [31:0] DEV_END   = DEV_BASE + 32'(DEV_COUNT * DEV_SPAN);

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [1:0] width,
                                           input logic [1:0] lo, input logic sext);
    logic [15:0] h;
    logic [7:0]  b;
    h = lo[1] ? w[31:16] : w[15:0];
    b = w[{lo, 3'b000} +: 8];
    case (width)
      2'b01:   return {{16{sext & h[15]}}, h};
      2'b10:   return {{24{sext & b[7]}}, b};
      default: return w;
    endcase
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         exc_q, exc_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               we_q, we_d;
  logic [1:0]         width_q, width_d;
  logic               sext_q, sext_d;
  logic [1:0]         lo_q, lo_d;
  logic               src_dev_q, src_dev_d;
  logic [31:0]        dev_rd_q, dev_rd_d;
  logic [31:0]        ram_rd_q;
  logic [31:0]        mem [RAM_WORDS];

  logic               accept;
  logic               dec_ram, dec_dev, dec_err;
  logic [31:0]        dev_off;
  logic [IDX_W-1:0]   dec_idx;
  logic [3:0]         dec_be;
  logic [31:0]        dec_wdata;
  logic [RAM_AW-1:0]  ram_idx;

  assign accept  = bus.req_valid && bus.req_ready;
  assign dev_off = bus.req_addr - DEV_BASE;
  assign dec_idx = IDX_W'(dev_off >> SPAN_SH);
  assign ram_idx = bus.req_addr[RAM_AW+1:2];

  // Address decode: reserved width first, then RAM, then device windows.
  always_comb begin
    dec_ram = 1'b0;
    dec_dev = 1'b0;
    dec_err = 1'b0;
    if (bus.req_width == 2'b11) begin
      dec_err = 1'b1;
    end else if (bus.req_addr < RAM_BYTES) begin
      if ((bus.req_width == 2'b00 && bus.req_addr[1:0] != 2'b00) ||
          (bus.req_width == 2'b01 && bus.req_addr[0]))
        dec_err = 1'b1;
      else
        dec_ram = 1'b1;
    end else if (bus.req_addr >= DEV_BASE && bus.req_addr < DEV_END) begin
      if (bus.req_width != 2'b00 || bus.req_addr[1:0] != 2'b00)
        dec_err = 1'b1;
      else
        dec_dev = 1'b1;
    end else begin
      dec_err = 1'b1;
    end
  end

  always_comb begin
    dec_be    = 4'b0001 << bus.req_addr[1:0];
    dec_wdata = {4{bus.req_wdata[7:0]}};
    case (bus.req_width)
      2'b00: begin
        dec_be    = 4'b1111;
        dec_wdata = bus.req_wdata;
      end
      2'b01: begin
        dec_be    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (accept && dec_ram) begin
      if (bus.req_we) begin
        for (int b = 0; b < 4; b++)
          if (dec_be[b]) mem[ram_idx][8*b +: 8] <= dec_wdata[8*b +: 8];
      end else begin
        ram_rd_q <= mem[ram_idx];
      end
    end
  end

  // State register; only control state is reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      exc_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exc_q   <= exc_d;
    end
    idx_q     <= idx_d;
    addr_q    <= addr_d;
    wdata_q   <= wdata_d;
    we_q      <= we_d;
    width_q   <= width_d;
    sext_q    <= sext_d;
    lo_q      <= lo_d;
    src_dev_q <= src_dev_d;
    dev_rd_q  <= dev_rd_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    exc_d     = exc_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    width_d   = width_q;
    sext_d    = sext_q;
    lo_d      = lo_q;
    src_dev_d = src_dev_q;
    dev_rd_d  = dev_rd_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d      = bus.req_we;
          width_d   = bus.req_width;
          sext_d    = bus.req_sext;
          lo_d      = bus.req_addr[1:0];
          src_dev_d = 1'b0;
          exc_d     = 2'd0;
          state_d   = RESP;
          if (dec_err) begin
            exc_d = bus.req_we ? 2'd2 : 2'd1;
          end else if (dec_dev) begin
            addr_d    = {bus.req_addr[31:2], 2'b00};
            wdata_d   = bus.req_wdata;
            idx_d     = dec_idx;
            cnt_d     = '0;
            src_dev_d = 1'b1;
            dev_rd_d  = 32'd0;
            state_d   = DEV;
          end
        end
      end
      DEV: begin
        // An ack on the timeout edge takes priority over the timeout.
        if (bus.dev_ack[idx_q]) begin
          dev_rd_d = bus.dev_rdata[32*idx_q +: 32];
          exc_d    = bus.dev_err[idx_q] ? 2'd3 : 2'd0;
          state_d  = RESP;
        end else if (cnt_q == CNT_W'(DEV_TIMEOUT - 1)) begin
          dev_rd_d = 32'd0;
          exc_d    = 2'd3;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = reset && (state_q == IDLE);
    bus.resp_valid = (state_q == RESP);
    bus.resp_exc   = (state_q == RESP) ? exc_q : 2'd0;
    bus.resp_rdata = 32'd0;
    if (state_q == RESP && exc_q == 2'd0 && !we_q)
      bus.resp_rdata = fmt_load(src_dev_q ? dev_rd_q : ram_rd_q, width_q, lo_q, sext_q);
    bus.dev_cyc    = (state_q == DEV);
    bus.dev_sel    = (state_q == DEV) ? DEV_COUNT'(1) << idx_q : '0;
    bus.dev_we     = (state_q == DEV) && we_q;
    bus.dev_addr   = addr_q;
    bus.dev_wdata  = wdata_q;
  end

endmodule
